// File: rtl/mem_io_bus.sv
// mem_io_bus: memory/I-O decode behind a single-cycle MIPS datapath.
// Routes the datapath's memaddr and writedata to data RAM, the write-only screen buffer,
// or an I/O bank. The I/O bank holds a keyboard FIFO, an LED register and a cycle counter.
// The readmem value is returned combinationally in the same cycle.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   memaddr, writedata           byte address and store data from the datapath
//   memwrite, memread            store and load strobes
//   readmem                      combinational load data
//   dmem_addr/we/wdata/rdata     data RAM port (asynchronous read)
//   scr_addr/we/wdata            screen buffer write port
//   kb_valid, kb_code            keyboard scan-code input
//   leds                         LED register
module mem_io_bus #(
  parameter int unsigned DMEM_AW  = 10,
  parameter int unsigned SCR_AW   = 12,
  parameter int unsigned KB_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         memaddr,
  input  logic [31:0]         writedata,
  input  logic                memwrite,
  input  logic                memread,
  output logic [31:0]         readmem,
  output logic [DMEM_AW-1:0]  dmem_addr,
  output logic                dmem_we,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata,
  output logic [SCR_AW-1:0]   scr_addr,
  output logic                scr_we,
  output logic [31:0]         scr_wdata,
  input  logic                kb_valid,
  input  logic [7:0]          kb_code,
  output logic [15:0]         leds
);

  localparam int unsigned PW = (KB_DEPTH > 2) ? $clog2(KB_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] OFF_KBSTAT = 3'd0;
  localparam logic [2:0] OFF_KBDATA = 3'd1;
  localparam logic [2:0] OFF_LED    = 3'd2;
  localparam logic [2:0] OFF_CYCLES = 3'd3;
  localparam logic [2:0] OFF_KBPEEK = 3'd4;

  // Region decode on the top nibble
  logic       sel_dmem, sel_scr, sel_io;
  logic [2:0] io_off;
  logic       io_wr, io_rd;

  assign sel_dmem = (memaddr[31:28] == 4'h1);
  assign sel_scr  = (memaddr[31:28] == 4'h2);
  assign sel_io   = (memaddr[31:28] == 4'h3);
  assign io_off   = memaddr[4:2];
  assign io_wr    = memwrite & sel_io;
  assign io_rd    = memread & sel_io;

  // Pass-through RAM and screen ports
  assign dmem_addr  = memaddr[DMEM_AW+1:2];
  assign dmem_we    = memwrite & sel_dmem;
  assign dmem_wdata = writedata;
  assign scr_addr   = memaddr[SCR_AW+1:2];
  assign scr_we     = memwrite & sel_scr;
  assign scr_wdata  = writedata;

  // Keep the whole address visibly consumed for every parameter choice
  logic unused_addr_bits;
  assign unused_addr_bits = ^memaddr;

  // Keyboard FIFO state
  logic [7:0]    kb_mem [KB_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] kb_count;
  logic          kb_ovf;
  logic [31:0]   cycles;

  logic       kb_empty, kb_full, kb_pop, kb_push, kb_drop;
  logic [7:0] kb_head;

  assign kb_empty = (kb_count == '0);
  assign kb_full  = (kb_count == CW'(KB_DEPTH));
  // Popping an empty FIFO is a no-op; a pop frees a slot for a same-cycle push
  assign kb_pop   = io_rd & (io_off == OFF_KBDATA) & ~kb_empty;
  assign kb_push  = kb_valid & (~kb_full | kb_pop);
  assign kb_drop  = kb_valid & kb_full & ~kb_pop;
  assign kb_head  = kb_mem[rd_ptr];

  // FIFO storage, needs no reset since count gates every read
  always_ff @(posedge clk) begin
    if (kb_push) kb_mem[wr_ptr] <= kb_code;
  end

  // Pointers, count, overflow, LEDs and cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      kb_count <= '0;
      kb_ovf   <= 1'b0;
      leds     <= '0;
      cycles   <= '0;
    end else begin
      if (kb_push) wr_ptr <= wr_ptr + PW'(1);
      if (kb_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({kb_push, kb_pop})
        2'b10:   kb_count <= kb_count + CW'(1);
        2'b01:   kb_count <= kb_count - CW'(1);
        default: kb_count <= kb_count;
      endcase
      // A dropped code outranks a same-cycle clear
      if (kb_drop)                           kb_ovf <= 1'b1;
      else if (io_wr && io_off == OFF_KBSTAT) kb_ovf <= 1'b0;
      if (io_wr && io_off == OFF_LED) leds <= writedata[15:0];
      if (io_wr && io_off == OFF_CYCLES) cycles <= writedata;
      else                               cycles <= cycles + 32'd1;
    end
  end

  // Combinational read mux
  logic [31:0] kbstat_word, kbdata_word;
  assign kbstat_word = {16'h0, 8'(kb_count), 5'b0, kb_ovf, kb_full, ~kb_empty};
  assign kbdata_word = kb_empty ? 32'h0 : {24'h0, kb_head};

  always_comb begin
    readmem = 32'h0;
    if (memread) begin
      if (sel_dmem) begin
        readmem = dmem_rdata;
      end else if (sel_io) begin
        case (io_off)
          OFF_KBSTAT: readmem = kbstat_word;
          OFF_KBDATA: readmem = kbdata_word;
          OFF_LED:    readmem = {16'h0, leds};
          OFF_CYCLES: readmem = cycles;
          OFF_KBPEEK: readmem = kbdata_word;
          default:    readmem = 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_io_bus.sv
// Directed self-checking bench for mem_io_bus.
module tb_mem_io_bus;

  logic        clk;
  logic        reset_n;
  logic [31:0] memaddr, writedata, readmem, dmem_wdata, dmem_rdata, scr_wdata;
  logic        memwrite, memread, dmem_we, scr_we, kb_valid;
  logic [9:0]  dmem_addr;
  logic [11:0] scr_addr;
  logic [7:0]  kb_code;
  logic [15:0] leds;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_KBSTAT = 32'h3000_0000;
  localparam logic [31:0] A_KBDATA = 32'h3000_0004;
  localparam logic [31:0] A_LED    = 32'h3000_0008;
  localparam logic [31:0] A_CYCLES = 32'h3000_000C;
  localparam logic [31:0] A_KBPEEK = 32'h3000_0010;

  mem_io_bus #(.DMEM_AW(10), .SCR_AW(12), .KB_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .memaddr(memaddr), .writedata(writedata),
    .memwrite(memwrite), .memread(memread), .readmem(readmem),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .scr_addr(scr_addr), .scr_we(scr_we),
    .scr_wdata(scr_wdata), .kb_valid(kb_valid), .kb_code(kb_code), .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    memwrite = 1'b0; memread = 1'b0; kb_valid = 1'b0;
    memaddr = 32'h0; writedata = 32'h0; kb_code = 8'h0;
  endtask

  // Load: present address with memread, settle, compare readmem
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    memaddr = addr; memread = 1'b1; memwrite = 1'b0;
    #1;
    check(tag, readmem, exp);
  endtask

  // Store: one cycle with memwrite high
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    memaddr = addr; writedata = data; memwrite = 1'b1; memread = 1'b0;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic push(input logic [7:0] code);
    kb_valid = 1'b1; kb_code = code;
    tick();
    kb_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    dmem_rdata = 32'hCAFE_BABE;
    idle();
    tick(); tick();
    check("leds_in_reset", 32'(leds), 32'h0);

    // Release just after an edge: counter shows 0, then 1, 2
    reset_n = 1'b1;
    rd(A_CYCLES, 32'h0, "cycles_first");
    rd(A_KBSTAT, 32'h0, "kbstat_after_reset");
    rd(A_LED, 32'h0, "led_after_reset");
    check("leds_after_reset", 32'(leds), 32'h0);
    tick();
    rd(A_CYCLES, 32'h1, "cycles_second");
    tick();
    rd(A_CYCLES, 32'h2, "cycles_third");

    // Counter load and wrap
    wr(A_CYCLES, 32'hFFFF_FFFE);
    rd(A_CYCLES, 32'hFFFF_FFFE, "cycles_loaded");
    tick();
    rd(A_CYCLES, 32'hFFFF_FFFF, "cycles_max");
    tick();
    rd(A_CYCLES, 32'h0, "cycles_wrap");
    idle();

    // Decode
    memaddr = 32'h1000_0010; writedata = 32'h1234_5678; memwrite = 1'b1;
    #1;
    check("dmem_we", 32'(dmem_we), 32'h1);
    check("dmem_addr", 32'(dmem_addr), 32'h4);
    check("dmem_wdata", dmem_wdata, 32'h1234_5678);
    check("scr_we_on_dmem", 32'(scr_we), 32'h0);
    memaddr = 32'h2000_0008;
    #1;
    check("scr_we", 32'(scr_we), 32'h1);
    check("scr_addr", 32'(scr_addr), 32'h2);
    check("scr_wdata", scr_wdata, 32'h1234_5678);
    check("dmem_we_on_scr", 32'(dmem_we), 32'h0);
    memaddr = 32'h4000_0000;
    #1;
    check("unmapped_dmem_we", 32'(dmem_we), 32'h0);
    check("unmapped_scr_we", 32'(scr_we), 32'h0);
    tick();
    idle();
    rd(32'h2000_0008, 32'h0, "lw_screen");
    rd(32'h1000_0010, 32'hCAFE_BABE, "lw_dmem");
    rd(32'h4000_0000, 32'h0, "lw_unmapped");
    memaddr = 32'h1000_0010; memread = 1'b0;
    #1;
    check("lw_no_memread", readmem, 32'h0);
    idle();
    tick();

    // FIFO fill and overflow
    for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
    rd(A_KBSTAT, 32'h0000_0803, "kbstat_full");
    idle();
    push(8'h19);
    rd(A_KBSTAT, 32'h0000_0807, "kbstat_overflow");

    // Drain in order, then a harmless extra pop
    for (int i = 0; i < 8; i++) begin
      rd(A_KBDATA, 32'(8'h11 + i), $sformatf("drain_%0d", i));
      tick();
    end
    rd(A_KBDATA, 32'h0, "pop_empty");
    tick();
    rd(A_KBSTAT, 32'h0000_0004, "kbstat_empty_ovf");
    wr(A_KBSTAT, 32'hDEAD_BEEF);
    rd(A_KBSTAT, 32'h0, "kbstat_cleared");
    idle();

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) push(8'(8'h41 + i));
    kb_valid = 1'b1; kb_code = 8'h2A;
    rd(A_KBDATA, 32'h41, "full_pushpop_head");
    tick();
    kb_valid = 1'b0;
    rd(A_KBSTAT, 32'h0000_0803, "full_pushpop_stat");
    for (int i = 0; i < 7; i++) begin
      rd(A_KBDATA, 32'(8'h42 + i), $sformatf("drain2_%0d", i));
      tick();
    end
    rd(A_KBDATA, 32'h2A, "last_out_2a");
    tick();
    rd(A_KBSTAT, 32'h0, "kbstat_empty2");

    // Simultaneous push and pop while empty
    kb_valid = 1'b1; kb_code = 8'h33;
    rd(A_KBDATA, 32'h0, "empty_pushpop_read");
    tick();
    kb_valid = 1'b0;
    rd(A_KBSTAT, 32'h0000_0101, "empty_pushpop_stat");
    rd(A_KBPEEK, 32'h33, "peek_first");
    tick();
    rd(A_KBPEEK, 32'h33, "peek_second");
    rd(A_KBSTAT, 32'h0000_0101, "peek_no_pop");
    idle();

    // LED register
    wr(A_LED, 32'hABCD_1234);
    check("leds_value", 32'(leds), 32'h1234);
    rd(A_LED, 32'h0000_1234, "lw_led");
    idle();

    // Fill, then a KBSTAT write colliding with a dropped push
    for (int i = 0; i < 7; i++) push(8'(8'h61 + i));
    kb_valid = 1'b1; kb_code = 8'h68;
    wr(A_KBSTAT, 32'h0);
    kb_valid = 1'b0;
    rd(A_KBSTAT, 32'h0000_0807, "ovf_set_wins");
    for (int i = 0; i < 5; i++) begin
      rd(A_KBDATA, (i == 0) ? 32'h33 : 32'(8'h61 + i - 1), $sformatf("drain3_%0d", i));
      tick();
    end
    rd(A_KBSTAT, 32'h0000_0305, "three_left_ovf");
    rd(A_KBPEEK, 32'h65, "peek_three_left");
    idle();
    wr(A_LED, 32'h0000_FFFF);
    check("leds_ffff", 32'(leds), 32'hFFFF);

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    check("async_leds", 32'(leds), 32'h0);
    rd(A_KBSTAT, 32'h0, "async_kbstat");
    rd(A_CYCLES, 32'h0, "async_cycles");
    memaddr = 32'h1000_0000; memread = 1'b0; memwrite = 1'b1;
    #1;
    check("dmem_we_in_reset", 32'(dmem_we), 32'h1);
    idle();
    tick();
    reset_n = 1'b1;
    rd(A_KBDATA, 32'h0, "kbdata_after_reset");
    rd(A_CYCLES, 32'h0, "cycles_after_reset");
    tick();
    rd(A_CYCLES, 32'h1, "cycles_after_reset_next");
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
